// File: rtl/avalon_mm_sdram_arb.sv
// Avalon-MM arbiter merging CH_CNT SDRAM masters onto one slave port, with in-order read return.
// Define AVALON_MM_SDRAM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module avalon_mm_sdram_arb #(
  parameter int CH_CNT            = 4,
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 64,
  parameter int BURST_COUNT_WIDTH = 8,
  parameter int BYTE_ENABLE_WIDTH = DATA_WIDTH / 8,
  parameter int RD_PEND_DEPTH     = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [CH_CNT*ADDR_WIDTH-1:0]          s_address_i,
  input  logic [CH_CNT*BURST_COUNT_WIDTH-1:0]   s_burst_count_i,
  input  logic [CH_CNT*DATA_WIDTH-1:0]          s_write_data_i,
  input  logic [CH_CNT*BYTE_ENABLE_WIDTH-1:0]   s_byte_enable_i,
  input  logic [CH_CNT-1:0]                     s_write_i,
  input  logic [CH_CNT-1:0]                     s_read_i,
  output logic [CH_CNT-1:0]                     s_wait_request_o,
  output logic [DATA_WIDTH-1:0]                 s_read_data_o,
  output logic [CH_CNT-1:0]                     s_readdata_val_o,
  output logic [ADDR_WIDTH-1:0]                 m_address_o,
  output logic [BURST_COUNT_WIDTH-1:0]          m_burst_count_o,
  output logic [DATA_WIDTH-1:0]                 m_write_data_o,
  output logic [BYTE_ENABLE_WIDTH-1:0]          m_byte_enable_o,
  output logic                                  m_write_o,
  output logic                                  m_read_o,
  input  logic                                  m_wait_request_i,
  input  logic [DATA_WIDTH-1:0]                 m_read_data_i,
  input  logic                                  m_readdata_val_i,
  output logic                                  rd_unexp_o
);
  localparam int CH_W  = $clog2(CH_CNT);
  localparam int PTR_W = $clog2(RD_PEND_DEPTH);
  localparam int BCW   = BURST_COUNT_WIDTH;

  typedef enum logic [1:0] {IDLE, CMD, WR_BURST} state_t;
  state_t state, state_nxt;

  logic [CH_W-1:0]  grant_ch, grant_nxt, rr_ptr, rr_nxt, grant_inc;
  logic [BCW-1:0]   beats_left, beats_nxt, burst_eff, head_cnt, head_burst;
  logic [CH_W-1:0]  pend_ch    [RD_PEND_DEPTH];
  logic [BCW-1:0]   pend_burst [RD_PEND_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   pend_cnt;
  logic             pend_full, pend_empty, push, pop, found;
  logic [CH_CNT-1:0] eligible;
  int               idx;

  always_comb begin
    m_address_o     = '0;
    m_burst_count_o = '0;
    m_write_data_o  = '0;
    m_byte_enable_o = '0;
    for (int k = 0; k < CH_CNT; k++) begin
      if (grant_ch == CH_W'(k)) begin
        m_address_o     = s_address_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        m_burst_count_o = s_burst_count_i[k*BCW +: BCW];
        m_write_data_o  = s_write_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        m_byte_enable_o = s_byte_enable_i[k*BYTE_ENABLE_WIDTH +: BYTE_ENABLE_WIDTH];
      end
    end
  end

  // A zero burst count behaves as a single beat everywhere.
  assign burst_eff  = (m_burst_count_o == '0) ? BCW'(1) : m_burst_count_o;
  assign grant_inc  = (grant_ch == CH_W'(CH_CNT - 1)) ? '0 : grant_ch + 1'b1;
  assign pend_empty = (pend_cnt == '0);
  assign pend_full  = (pend_cnt == (PTR_W+1)'(RD_PEND_DEPTH));
  assign eligible   = s_write_i | (s_read_i & {CH_CNT{~pend_full}});
  assign head_burst = pend_burst[rd_ptr];
  assign pop = m_readdata_val_i && !pend_empty &&
               (({1'b0, head_cnt} + (BCW+1)'(1)) == {1'b0, head_burst});

  always_comb begin
    grant_nxt = grant_ch;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < CH_CNT; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= CH_CNT) idx = idx - CH_CNT;
      if (!found && eligible[CH_W'(idx)]) begin
        found     = 1'b1;
        grant_nxt = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    beats_nxt        = beats_left;
    rr_nxt           = rr_ptr;
    m_write_o        = 1'b0;
    m_read_o         = 1'b0;
    s_wait_request_o = '1;
    push             = 1'b0;
    case (state)
      IDLE: if (found) state_nxt = CMD;
      CMD: begin
        m_write_o = s_write_i[grant_ch];
        m_read_o  = s_read_i[grant_ch] & ~s_write_i[grant_ch];
        s_wait_request_o[grant_ch] = m_wait_request_i;
        if (!m_wait_request_i) begin
          if (m_read_o) begin
            push      = 1'b1;
            state_nxt = IDLE;
            rr_nxt    = grant_inc;
          end else if (m_write_o) begin
            if (burst_eff > BCW'(1)) begin
              beats_nxt = burst_eff - 1'b1;
              state_nxt = WR_BURST;
            end else begin
              state_nxt = IDLE;
              rr_nxt    = grant_inc;
            end
          end
        end
      end
      WR_BURST: begin
        // Grant stays locked; a master dropping write only stalls the burst.
        m_write_o = s_write_i[grant_ch];
        s_wait_request_o[grant_ch] = m_wait_request_i;
        if (m_write_o && !m_wait_request_i) begin
          beats_nxt = beats_left - 1'b1;
          if (beats_left == BCW'(1)) begin
            state_nxt = IDLE;
            rr_nxt    = grant_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef AVALON_MM_SDRAM_ARB_FIXED_PRIO_EN
    rr_nxt = '0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant_ch   <= '0;
      rr_ptr     <= '0;
      beats_left <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_nxt;
      beats_left <= beats_nxt;
      if (state == IDLE && found) grant_ch <= grant_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pend_ch[wr_ptr]    <= grant_ch;
      pend_burst[wr_ptr] <= burst_eff;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      pend_cnt         <= '0;
      head_cnt         <= '0;
      s_read_data_o    <= '0;
      s_readdata_val_o <= '0;
      rd_unexp_o       <= 1'b0;
    end else begin
      s_readdata_val_o <= '0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        head_cnt <= '0;
      end else if (m_readdata_val_i && !pend_empty) begin
        head_cnt <= head_cnt + 1'b1;
      end
      if (push && !pop)      pend_cnt <= pend_cnt + 1'b1;
      else if (pop && !push) pend_cnt <= pend_cnt - 1'b1;
      if (m_readdata_val_i) begin
        s_read_data_o <= m_read_data_i;
        if (pend_empty) rd_unexp_o <= 1'b1;
        else            s_readdata_val_o[pend_ch[rd_ptr]] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_avalon_mm_sdram_arb.sv
// Scoreboard bench for avalon_mm_sdram_arb: directed stimulus pushes expected commands and
// read returns into queues; a negedge monitor pops and compares whenever the DUT presents one.
module tb_avalon_mm_sdram_arb;
  localparam int CH = 4, AW = 32, DW = 64, BW = 8, EW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH*AW-1:0]  s_address_i;
  logic [CH*BW-1:0]  s_burst_count_i;
  logic [CH*DW-1:0]  s_write_data_i;
  logic [CH*EW-1:0]  s_byte_enable_i;
  logic [CH-1:0]     s_write_i, s_read_i;
  logic [CH-1:0]     s_wait_request_o;
  logic [DW-1:0]     s_read_data_o;
  logic [CH-1:0]     s_readdata_val_o;
  logic [AW-1:0]     m_address_o;
  logic [BW-1:0]     m_burst_count_o;
  logic [DW-1:0]     m_write_data_o;
  logic [EW-1:0]     m_byte_enable_o;
  logic              m_write_o, m_read_o;
  logic              m_wait_request_i;
  logic [DW-1:0]     m_read_data_i;
  logic              m_readdata_val_i;
  logic              rd_unexp_o;

  avalon_mm_sdram_arb dut (
    .clk_i(clk), .rst_i(rst),
    .s_address_i(s_address_i), .s_burst_count_i(s_burst_count_i),
    .s_write_data_i(s_write_data_i), .s_byte_enable_i(s_byte_enable_i),
    .s_write_i(s_write_i), .s_read_i(s_read_i),
    .s_wait_request_o(s_wait_request_o), .s_read_data_o(s_read_data_o),
    .s_readdata_val_o(s_readdata_val_o),
    .m_address_o(m_address_o), .m_burst_count_o(m_burst_count_o),
    .m_write_data_o(m_write_data_o), .m_byte_enable_o(m_byte_enable_o),
    .m_write_o(m_write_o), .m_read_o(m_read_o),
    .m_wait_request_i(m_wait_request_i), .m_read_data_i(m_read_data_i),
    .m_readdata_val_i(m_readdata_val_i), .rd_unexp_o(rd_unexp_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] bc;
    logic [DW-1:0] data;
    logic [EW-1:0] be;
  } cmd_t;
  typedef struct {
    logic [CH-1:0] val;
    logic [DW-1:0] data;
  } rd_t;

  cmd_t cmd_q[$];
  rd_t  rd_q[$];
  cmd_t ce;
  rd_t  re;
  int   vectors = 0, miscompares = 0;
  int   acc_cnt = 0;
  int   acc_cyc[$];
  logic last_mval = 1'b0;

  function automatic logic [AW-1:0] addr_of(input int ch);
    return 32'h1000_0000 + 32'(ch) * 32'h100;
  endfunction
  function automatic logic [DW-1:0] data_of(input int ch);
    return 64'hDA7A_0000_0000_0000 + 64'(ch);
  endfunction
  function automatic logic [EW-1:0] be_of(input int ch);
    return 8'((ch + 1) * 17);
  endfunction
  function automatic cmd_t mk_cmd(input logic wr, input int ch, input int bc, input logic [DW-1:0] d);
    cmd_t c;
    c.wr = wr; c.addr = addr_of(ch); c.bc = BW'(bc); c.data = d; c.be = be_of(ch);
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (m_write_o || m_read_o) && !m_wait_request_i) begin
      acc_cnt++;
      acc_cyc.push_back(cyc);
      if (cmd_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL cmd_unexpected: got wr=%0b rd=%0b addr=%0h expected none", m_write_o, m_read_o, m_address_o);
      end else begin
        ce = cmd_q.pop_front();
        chk("cmd_wr", m_write_o, ce.wr);
        chk("cmd_rd", m_read_o, !ce.wr);
        chk("cmd_addr", m_address_o, ce.addr);
        chk("cmd_bc", m_burst_count_o, ce.bc);
        if (ce.wr) begin
          chk("cmd_data", m_write_data_o, ce.data);
          chk("cmd_be", m_byte_enable_o, ce.be);
        end
      end
    end
    if (s_readdata_val_o != '0) begin
      chk("rd_latency", last_mval, 1);
      if (rd_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL rd_unexpected_valid: got %b expected none", s_readdata_val_o);
      end else begin
        re = rd_q.pop_front();
        chk("rd_val", s_readdata_val_o, re.val);
        chk("rd_data", s_read_data_o, re.data);
      end
    end
    last_mval = m_readdata_val_i;
  end

  task automatic wait_acc(input int target, input string name);
    int n = 0;
    while (acc_cnt < target && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (acc_cnt < target) begin
      vectors++; miscompares++;
      $display("FAIL %s timeout: accepts %0d expected %0d", name, acc_cnt, target);
    end
  endtask

  task automatic rd_beat(input logic [DW-1:0] d);
    m_readdata_val_i = 1'b1; m_read_data_i = d;
    @(posedge clk); #1;
    m_readdata_val_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int   exp_ch[5];
  int   beat, n;
  logic waited, done, a1, a2;

  initial begin
    for (int k = 0; k < CH; k++) begin
      s_address_i[k*AW +: AW]     = addr_of(k);
      s_burst_count_i[k*BW +: BW] = 8'd1;
      s_write_data_i[k*DW +: DW]  = data_of(k);
      s_byte_enable_i[k*EW +: EW] = be_of(k);
    end
    m_wait_request_i = 1'b0; m_read_data_i = '0; m_readdata_val_i = 1'b0;

    // Reset held for 3 cycles with every request asserted
    rst = 1'b1; s_write_i = '1; s_read_i = '1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("rst_m_write", m_write_o, 0);
      chk("rst_m_read", m_read_o, 0);
      chk("rst_wait", s_wait_request_o, 4'b1111);
      chk("rst_unexp", rd_unexp_o, 0);
      chk("rst_rdval", s_readdata_val_o, 0);
    end
    s_write_i = '0; s_read_i = '0; rst = 1'b0;
    @(posedge clk); #1;

    // Round-robin over continuous single-beat writes
`ifdef AVALON_MM_SDRAM_ARB_FIXED_PRIO_EN
    exp_ch = '{0, 0, 0, 0, 0};
`else
    exp_ch = '{0, 1, 2, 3, 0};
`endif
    foreach (exp_ch[i]) cmd_q.push_back(mk_cmd(1'b1, exp_ch[i], 1, data_of(exp_ch[i])));
    acc_cyc.delete();
    s_write_i = 4'b1111;
    wait_acc(acc_cnt + 5, "rr");
    s_write_i = '0;
    if (acc_cyc.size() >= 5)
      for (int i = 1; i < 5; i++) chk("rr_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 2);
    @(posedge clk); #1;

    // Channel 1 burst of 4 with a wait on beat 2 while channel 2 competes
    s_burst_count_i[1*BW +: BW] = 8'd4;
    s_write_data_i[1*DW +: DW]  = 64'hB001;
    for (int b = 1; b <= 4; b++) cmd_q.push_back(mk_cmd(1'b1, 1, 4, 64'hB000 + 64'(b)));
    cmd_q.push_back(mk_cmd(1'b1, 2, 1, data_of(2)));
    s_write_i[1] = 1'b1; s_write_i[2] = 1'b1;
    beat = 1; waited = 1'b0; done = 1'b0; n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      a1 = m_write_o && !m_wait_request_i && !s_wait_request_o[1];
      a2 = m_write_o && !m_wait_request_i && !s_wait_request_o[2];
      @(posedge clk); #1; n++;
      if (a1) begin
        beat++;
        if (beat > 4) s_write_i[1] = 1'b0;
        else s_write_data_i[1*DW +: DW] = 64'hB000 + 64'(beat);
      end
      if (a2) begin s_write_i[2] = 1'b0; done = 1'b1; end
      if (beat == 2 && !waited) begin m_wait_request_i = 1'b1; waited = 1'b1; end
      else m_wait_request_i = 1'b0;
    end
    chk("burst_done", done, 1);
    s_burst_count_i[1*BW +: BW] = 8'd1;
    s_write_data_i[1*DW +: DW]  = data_of(1);
    m_wait_request_i = 1'b0;

    // Read routing: ch0 burst 2 then ch3 burst 3, five beats returned in order
    s_burst_count_i[0*BW +: BW] = 8'd2;
    s_burst_count_i[3*BW +: BW] = 8'd3;
    cmd_q.push_back(mk_cmd(1'b0, 0, 2, '0));
    cmd_q.push_back(mk_cmd(1'b0, 3, 3, '0));
    s_read_i[0] = 1'b1; wait_acc(acc_cnt + 1, "rd_ch0"); s_read_i[0] = 1'b0;
    s_read_i[3] = 1'b1; wait_acc(acc_cnt + 1, "rd_ch3"); s_read_i[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      re.val = (i < 2) ? 4'b0001 : 4'b1000;
      re.data = 64'hCAFE_0000 + 64'(i);
      rd_q.push_back(re);
    end
    for (int i = 0; i < 5; i++) begin
      rd_beat(64'hCAFE_0000 + 64'(i));
      if (i == 2) begin @(posedge clk); #1; end
    end
    repeat (3) @(posedge clk); #1;
    chk("rd_routing_drained", 64'(rd_q.size()), 0);

    // Fill the pending FIFO with 16 reads; writes continue, the 17th read waits
    for (int i = 0; i < 16; i++) cmd_q.push_back(mk_cmd(1'b0, 0, 2, '0));
    s_read_i[0] = 1'b1;
    wait_acc(acc_cnt + 16, "fill");
    for (int i = 0; i < 3; i++) cmd_q.push_back(mk_cmd(1'b1, 1, 1, data_of(1)));
    s_write_i[1] = 1'b1;
    wait_acc(acc_cnt + 3, "wr_while_full");
    s_write_i[1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("full_read_blocked", m_read_o, 0);
      chk("full_ch0_wait", s_wait_request_o[0], 1);
    end
    cmd_q.push_back(mk_cmd(1'b0, 0, 2, '0));
    re.val = 4'b0001; re.data = 64'hF00D_0000; rd_q.push_back(re);
    re.val = 4'b0001; re.data = 64'hF00D_0001; rd_q.push_back(re);
    @(posedge clk); #1;
    rd_beat(64'hF00D_0000);
    rd_beat(64'hF00D_0001);
    wait_acc(acc_cnt + 1, "read_after_pop");
    s_read_i[0] = 1'b0;

    // Unexpected read data after reset clears the FIFO
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk("unexp_cleared", rd_unexp_o, 0);
    rd_beat(64'hDEAD);
    chk("unexp_set", rd_unexp_o, 1);
    chk("unexp_no_valid", s_readdata_val_o, 0);
    repeat (3) @(posedge clk); #1;
    chk("unexp_sticky", rd_unexp_o, 1);

    // Reset mid-burst with an outstanding read: abort, all waits high, read discarded
    s_burst_count_i[0*BW +: BW] = 8'd1;
    cmd_q.push_back(mk_cmd(1'b0, 0, 1, '0));
    s_read_i[0] = 1'b1; wait_acc(acc_cnt + 1, "pre_rst_read"); s_read_i[0] = 1'b0;
    s_burst_count_i[2*BW +: BW] = 8'd4;
    cmd_q.push_back(mk_cmd(1'b1, 2, 4, data_of(2)));
    s_write_i[2] = 1'b1;
    wait_acc(acc_cnt + 1, "burst_start");
    rst = 1'b1; @(posedge clk); #1;
    chk("mrst_m_write", m_write_o, 0);
    chk("mrst_wait", s_wait_request_o, 4'b1111);
    chk("mrst_unexp", rd_unexp_o, 0);
    @(posedge clk); #1;
    chk("mrst_no_regrant", m_write_o, 0);
    s_write_i[2] = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rd_beat(64'hBEEF);
    chk("mrst_fifo_empty", rd_unexp_o, 1);
    chk("mrst_no_valid", s_readdata_val_o, 0);
    repeat (2) @(posedge clk); #1;

    chk("cmd_q_empty", 64'(cmd_q.size()), 0);
    chk("rd_q_empty", 64'(rd_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
